// File: rtl/lock_on_ctrl_pkg.sv
// Shared constants, state encoding and distance helpers for the lock-on controller.
package lock_on_ctrl_pkg;

  localparam int unsigned N_TGT         = 16;
  localparam int unsigned IDX_W         = $clog2(N_TGT);
  localparam int unsigned PICK_RADIUS   = 48;
  localparam int unsigned LOST_FRAMES   = 30;
  localparam int unsigned LOST_W        = $clog2(LOST_FRAMES + 1);
  localparam int unsigned CENTER_X      = 320;
  localparam int unsigned CENTER_Y      = 240;
  localparam int unsigned CENTER_HALF_W = 32;
  localparam int unsigned CENTER_HALF_H = 32;

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    LOCKED,
    COAST,
    NEXT
  } lock_state_t;

  // L1 distance between two 10-bit screen points; 11 bits cannot overflow.
  function automatic logic [10:0] l1_dist(input logic [9:0] ax, input logic [9:0] ay,
                                          input logic [9:0] bx, input logic [9:0] by);
    logic [9:0] ddx;
    logic [9:0] ddy;
    ddx = (ax >= bx) ? (ax - bx) : (bx - ax);
    ddy = (ay >= by) ? (ay - by) : (by - ay);
    return {1'b0, ddx} + {1'b0, ddy};
  endfunction

  // Magnitude of an 11-bit two's complement value (operand range never hits -1024).
  function automatic logic [10:0] abs11(input logic [10:0] v);
    return v[10] ? (~v + 11'd1) : v;
  endfunction

endpackage

// File: rtl/lock_on_ctrl_if.sv
// Bundle of detection/mouse inputs and lock status outputs of the lock-on controller.
interface lock_on_ctrl_if;

  logic                                          frame_start;
  logic [lock_on_ctrl_pkg::N_TGT-1:0][9:0]       aim_x_all;
  logic [lock_on_ctrl_pkg::N_TGT-1:0][9:0]       aim_y_all;
  logic [lock_on_ctrl_pkg::N_TGT-1:0]            aim_detected_all;
  logic [9:0]                                    mouse_x_pixel;
  logic [9:0]                                    mouse_y_pixel;
  logic                                          click_l;
  logic                                          click_r;
  logic                                          click_m;
  logic                                          is_locked;
  logic [lock_on_ctrl_pkg::IDX_W-1:0]            locked_idx;
  logic                                          center_hit;
  logic                                          target_off;
  logic [10:0]                                   err_dx;
  logic [10:0]                                   err_dy;
  logic                                          busy;

  modport master (
    output frame_start, aim_x_all, aim_y_all, aim_detected_all,
           mouse_x_pixel, mouse_y_pixel, click_l, click_r, click_m,
    input  is_locked, locked_idx, center_hit, target_off, err_dx, err_dy, busy
  );

  modport slave (
    input  frame_start, aim_x_all, aim_y_all, aim_detected_all,
           mouse_x_pixel, mouse_y_pixel, click_l, click_r, click_m,
    output is_locked, locked_idx, center_hit, target_off, err_dx, err_dy, busy
  );

endinterface

// File: rtl/lock_on_ctrl_click_edge_det.sv
// Rising-edge detector for the three mouse buttons; history starts at 1 so a
// button held through reset does not produce an edge.
module click_edge_det (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] btn,
  output logic [2:0] rise
);

  logic [2:0] prev;

  // Button history register.
  always_ff @(posedge clk) begin
    if (reset) prev <= '1;
    else       prev <= btn;
  end

  // Edge is current level high with previous level low.
  always_comb begin
    rise = btn & ~prev;
  end

endmodule

// File: rtl/lock_on_ctrl.sv
// Lock-on controller: picks a target by mouse click, holds it across detection
// dropouts, releases on right-click or after LOST_FRAMES missed frames.
// Optional feature: define LOCK_NEXT_TARGET_EN to let a middle-click step the
// lock to the next detected slot.
module lock_on_ctrl
  import lock_on_ctrl_pkg::*;
(
  input logic           clk,
  input logic           reset,
  lock_on_ctrl_if.slave bus
);

  lock_state_t       state;
  logic [2:0]        rise;
  logic              rise_l;
  logic              rise_r;

  logic [IDX_W-1:0]  scan_k;
  logic [IDX_W-1:0]  best_idx;
  logic [10:0]       best_d;
  logic              found;
  logic [9:0]        mx;
  logic [9:0]        my;
  logic [LOST_W-1:0] lost_cnt;
  logic [LOST_W-1:0] lost_next;

  logic              is_locked;
  logic [IDX_W-1:0]  locked_idx;
  logic              center_hit;
  logic              target_off;
  logic [10:0]       err_dx;
  logic [10:0]       err_dy;
  logic              busy;

  logic [10:0]       slot_d;
  logic              cand;
  logic              last;
  logic              lk_det;
  logic [10:0]       dx;
  logic [10:0]       dy;
  logic              hit;
  logic              to_idle;

`ifdef LOCK_NEXT_TARGET_EN
  logic              rise_m;
  logic [IDX_W-1:0]  step_cnt;
  lock_state_t       prior;
  assign rise_m = rise[2];
`else
  logic              unused_rise_m;
  assign unused_rise_m = rise[2];
`endif

  assign rise_l = rise[0];
  assign rise_r = rise[1];

  click_edge_det u_edge (
    .clk   (clk),
    .reset (reset),
    .btn   ({bus.click_m, bus.click_r, bus.click_l}),
    .rise  (rise)
  );

  // Slot evaluation, locked-target error terms and the drop-to-IDLE decision.
  always_comb begin
    slot_d    = l1_dist(bus.aim_x_all[scan_k], bus.aim_y_all[scan_k], mx, my);
    cand      = bus.aim_detected_all[scan_k] && (slot_d <= 11'(PICK_RADIUS)) &&
                (!found || (slot_d < best_d));
    last      = (scan_k == IDX_W'(N_TGT - 1));
    lk_det    = bus.aim_detected_all[locked_idx];
    dx        = {1'b0, bus.aim_x_all[locked_idx]} - 11'(CENTER_X);
    dy        = {1'b0, bus.aim_y_all[locked_idx]} - 11'(CENTER_Y);
    hit       = (abs11(dx) < 11'(CENTER_HALF_W)) && (abs11(dy) < 11'(CENTER_HALF_H));
    lost_next = (lost_cnt == LOST_W'(LOST_FRAMES)) ? lost_cnt : lost_cnt + 1'b1;
    to_idle   = 1'b0;
    case (state)
      IDLE:   to_idle = 1'b0;
      SCAN:   to_idle = rise_r || (last && !cand && !found);
      LOCKED: to_idle = rise_r;
`ifdef LOCK_NEXT_TARGET_EN
      COAST:  to_idle = rise_r || (!rise_m && bus.frame_start && !lk_det &&
                                   (lost_next == LOST_W'(LOST_FRAMES)));
      NEXT:   to_idle = rise_r;
`else
      COAST:  to_idle = rise_r || (bus.frame_start && !lk_det &&
                                   (lost_next == LOST_W'(LOST_FRAMES)));
`endif
      default: to_idle = 1'b1;
    endcase
  end

  // Main FSM with registered outputs. Every path into IDLE is collected in
  // to_idle and applied after the case so it overrides any branch update.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      scan_k     <= '0;
      best_idx   <= '0;
      best_d     <= '1;
      found      <= 1'b0;
      mx         <= '0;
      my         <= '0;
      lost_cnt   <= '0;
      is_locked  <= 1'b0;
      locked_idx <= '0;
      center_hit <= 1'b0;
      target_off <= 1'b0;
      err_dx     <= '0;
      err_dy     <= '0;
      busy       <= 1'b0;
`ifdef LOCK_NEXT_TARGET_EN
      step_cnt   <= '0;
      prior      <= IDLE;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (rise_l) begin
            state  <= SCAN;
            mx     <= bus.mouse_x_pixel;
            my     <= bus.mouse_y_pixel;
            scan_k <= '0;
            found  <= 1'b0;
            best_d <= '1;
            busy   <= 1'b1;
          end
        end
        SCAN: begin
          if (cand) begin
            found    <= 1'b1;
            best_d   <= slot_d;
            best_idx <= scan_k;
          end
          if (last) begin
            busy       <= 1'b0;
            state      <= LOCKED;
            is_locked  <= 1'b1;
            target_off <= 1'b0;
            lost_cnt   <= '0;
            locked_idx <= cand ? scan_k : best_idx;
          end else begin
            scan_k <= scan_k + 1'b1;
          end
        end
        LOCKED: begin
          err_dx     <= dx;
          err_dy     <= dy;
          center_hit <= hit;
          if (rise_l) begin
            state      <= SCAN;
            mx         <= bus.mouse_x_pixel;
            my         <= bus.mouse_y_pixel;
            scan_k     <= '0;
            found      <= 1'b0;
            best_d     <= '1;
            busy       <= 1'b1;
            is_locked  <= 1'b0;
            target_off <= 1'b0;
            lost_cnt   <= '0;
          end
`ifdef LOCK_NEXT_TARGET_EN
          else if (rise_m) begin
            state    <= NEXT;
            prior    <= LOCKED;
            scan_k   <= locked_idx + 1'b1;
            step_cnt <= IDX_W'(1);
            busy     <= 1'b1;
          end
`endif
          else if (bus.frame_start && !lk_det) begin
            state      <= COAST;
            lost_cnt   <= LOST_W'(1);
            target_off <= 1'b1;
          end
        end
        COAST: begin
`ifdef LOCK_NEXT_TARGET_EN
          if (rise_m) begin
            state    <= NEXT;
            prior    <= COAST;
            scan_k   <= locked_idx + 1'b1;
            step_cnt <= IDX_W'(1);
            busy     <= 1'b1;
          end else
`endif
          if (bus.frame_start) begin
            if (lk_det) begin
              state      <= LOCKED;
              lost_cnt   <= '0;
              target_off <= 1'b0;
            end else begin
              lost_cnt <= lost_next;
            end
          end
        end
`ifdef LOCK_NEXT_TARGET_EN
        NEXT: begin
          if (bus.aim_detected_all[scan_k]) begin
            locked_idx <= scan_k;
            lost_cnt   <= '0;
            target_off <= 1'b0;
            state      <= LOCKED;
            busy       <= 1'b0;
          end else if (step_cnt == IDX_W'(N_TGT - 1)) begin
            state <= prior;
            busy  <= 1'b0;
          end else begin
            scan_k   <= scan_k + 1'b1;
            step_cnt <= step_cnt + 1'b1;
          end
        end
`endif
        default: ;
      endcase

      if (to_idle) begin
        state      <= IDLE;
        is_locked  <= 1'b0;
        target_off <= 1'b0;
        center_hit <= 1'b0;
        err_dx     <= '0;
        err_dy     <= '0;
        busy       <= 1'b0;
        lost_cnt   <= '0;
      end
    end
  end

  assign bus.is_locked  = is_locked;
  assign bus.locked_idx = locked_idx;
  assign bus.center_hit = center_hit;
  assign bus.target_off = target_off;
  assign bus.err_dx     = err_dx;
  assign bus.err_dy     = err_dy;
  assign bus.busy       = busy;

endmodule

// File: tb/tb_lock_on_ctrl.sv
// Directed testbench for lock_on_ctrl; the middle-click section follows
// LOCK_NEXT_TARGET_EN the same way the design does.
module tb_lock_on_ctrl;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  int   busy_n;

  lock_on_ctrl_if bus ();

  lock_on_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] e11(input int v);
    return 32'(v) & 32'h7FF;
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_tgts();
    bus.aim_x_all        = '0;
    bus.aim_y_all        = '0;
    bus.aim_detected_all = '0;
  endtask

  task automatic set_tgt(input int k, input int x, input int y);
    bus.aim_x_all[k]        = 10'(x);
    bus.aim_y_all[k]        = 10'(y);
    bus.aim_detected_all[k] = 1'b1;
  endtask

  // Left-click pulse, then count busy cycles over a fixed 20-cycle window.
  task automatic pick(input int x, input int y, output int n);
    bus.mouse_x_pixel = 10'(x);
    bus.mouse_y_pixel = 10'(y);
    bus.click_l = 1'b1;
    step(1);
    bus.click_l = 1'b0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.busy) n++;
      step(1);
    end
  endtask

  task automatic rclick();
    bus.click_r = 1'b1;
    step(1);
    bus.click_r = 1'b0;
  endtask

  task automatic frame();
    bus.frame_start = 1'b1;
    step(1);
    bus.frame_start = 1'b0;
    step(1);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset = 1'b1;
    bus.frame_start = 1'b0;
    bus.mouse_x_pixel = '0;
    bus.mouse_y_pixel = '0;
    bus.click_l = 1'b0;
    bus.click_r = 1'b0;
    bus.click_m = 1'b0;
    clear_tgts();
    step(3);
    check("rst_locked", 32'(bus.is_locked), 0);
    check("rst_busy",   32'(bus.busy), 0);
    check("rst_idx",    32'(bus.locked_idx), 0);
    check("rst_dx",     32'(bus.err_dx), 0);
    check("rst_hit",    32'(bus.center_hit), 0);
    check("rst_off",    32'(bus.target_off), 0);
    reset = 1'b0;
    step(1);

    // 1: basic pick of slot 5 and centre window edges
    set_tgt(5, 300, 230);
    pick(310, 240, busy_n);
    check("t1_busy_cycles", 32'(busy_n), 16);
    check("t1_locked", 32'(bus.is_locked), 1);
    check("t1_idx",    32'(bus.locked_idx), 5);
    check("t1_dx",     32'(bus.err_dx), e11(-20));
    check("t1_dy",     32'(bus.err_dy), e11(-10));
    check("t1_hit",    32'(bus.center_hit), 1);
    check("t1_off",    32'(bus.target_off), 0);
    bus.aim_x_all[5] = 10'd288;
    step(2);
    check("t1_dx288",  32'(bus.err_dx), e11(-32));
    check("t1_hit288", 32'(bus.center_hit), 0);
    bus.aim_x_all[5] = 10'd351;
    step(2);
    check("t1_hit351", 32'(bus.center_hit), 1);
    bus.aim_x_all[5] = 10'd300;
    step(2);
    rclick();
    check("t1_rel_locked", 32'(bus.is_locked), 0);
    check("t1_rel_dx",     32'(bus.err_dx), 0);
    check("t1_rel_hit",    32'(bus.center_hit), 0);

    // 2: tie -> lowest slot; radius boundary 48 vs 49; failed re-pick drops lock
    clear_tgts();
    set_tgt(2, 100, 100);
    set_tgt(9, 120, 100);
    bus.aim_x_all[4] = 10'd110;
    bus.aim_y_all[4] = 10'd110;
    pick(110, 110, busy_n);
    check("t2_tie_locked", 32'(bus.is_locked), 1);
    check("t2_tie_idx",    32'(bus.locked_idx), 2);
    rclick();
    clear_tgts();
    set_tgt(3, 200, 200);
    pick(249, 200, busy_n);
    check("t2_d49_busy",   32'(busy_n), 16);
    check("t2_d49_locked", 32'(bus.is_locked), 0);
    pick(248, 200, busy_n);
    check("t2_d48_locked", 32'(bus.is_locked), 1);
    check("t2_d48_idx",    32'(bus.locked_idx), 3);
    pick(600, 400, busy_n);
    check("t2_repick_miss_locked", 32'(bus.is_locked), 0);
    check("t2_repick_miss_busy",   32'(bus.busy), 0);

    // 3: coast for 29 frames, recover, then lose after 30
    clear_tgts();
    set_tgt(5, 300, 230);
    pick(310, 240, busy_n);
    bus.aim_detected_all[5] = 1'b0;
    frame();
    check("t3_coast_off",    32'(bus.target_off), 1);
    check("t3_coast_locked", 32'(bus.is_locked), 1);
    bus.aim_x_all[5] = 10'd400;
    step(2);
    check("t3_frozen_dx", 32'(bus.err_dx), e11(-20));
    bus.aim_x_all[5] = 10'd300;
    for (int i = 0; i < 28; i++) frame();
    check("t3_29_locked", 32'(bus.is_locked), 1);
    check("t3_29_off",    32'(bus.target_off), 1);
    bus.aim_detected_all[5] = 1'b1;
    frame();
    check("t3_redet_off",    32'(bus.target_off), 0);
    check("t3_redet_locked", 32'(bus.is_locked), 1);
    check("t3_redet_idx",    32'(bus.locked_idx), 5);
    bus.aim_detected_all[5] = 1'b0;
    for (int i = 0; i < 29; i++) frame();
    check("t3_pre30_locked", 32'(bus.is_locked), 1);
    frame();
    check("t3_30_locked", 32'(bus.is_locked), 0);
    check("t3_30_off",    32'(bus.target_off), 0);

    // 4: right and left click rise together while locked
    bus.aim_detected_all[5] = 1'b1;
    pick(310, 240, busy_n);
    check("t4_pre_locked", 32'(bus.is_locked), 1);
    bus.click_r = 1'b1;
    bus.click_l = 1'b1;
    step(1);
    bus.click_r = 1'b0;
    bus.click_l = 1'b0;
    check("t4_locked", 32'(bus.is_locked), 0);
    check("t4_busy",   32'(bus.busy), 0);
    step(3);
    check("t4_busy_later", 32'(bus.busy), 0);

    // 5: click held through reset; reset mid-scan
    bus.click_l = 1'b1;
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    step(3);
    check("t5_held_busy",   32'(bus.busy), 0);
    check("t5_held_locked", 32'(bus.is_locked), 0);
    bus.click_l = 1'b0;
    step(1);
    pick(310, 240, busy_n);
    check("t5_pre_idx", 32'(bus.locked_idx), 5);
    bus.click_l = 1'b1;
    step(1);
    bus.click_l = 1'b0;
    step(4);
    check("t5_midscan_busy", 32'(bus.busy), 1);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    check("t5_rst_busy",   32'(bus.busy), 0);
    check("t5_rst_locked", 32'(bus.is_locked), 0);
    check("t5_rst_idx",    32'(bus.locked_idx), 0);
    check("t5_rst_dx",     32'(bus.err_dx), 0);
    check("t5_rst_dy",     32'(bus.err_dy), 0);
    check("t5_rst_hit",    32'(bus.center_hit), 0);
    step(20);
    check("t5_after_busy", 32'(bus.busy), 0);

    // 6: middle click
`ifdef LOCK_NEXT_TARGET_EN
    clear_tgts();
    set_tgt(14, 300, 230);
    pick(310, 240, busy_n);
    check("t6_idx14", 32'(bus.locked_idx), 14);
    set_tgt(3, 100, 100);
    set_tgt(15, 500, 100);
    bus.click_m = 1'b1;
    step(1);
    bus.click_m = 1'b0;
    check("t6_next_busy",   32'(bus.busy), 1);
    check("t6_next_locked", 32'(bus.is_locked), 1);
    step(3);
    check("t6_idx15", 32'(bus.locked_idx), 15);
    check("t6_busy15", 32'(bus.busy), 0);
    bus.click_m = 1'b1;
    step(1);
    bus.click_m = 1'b0;
    step(6);
    check("t6_idx3",    32'(bus.locked_idx), 3);
    check("t6_locked3", 32'(bus.is_locked), 1);
`else
    clear_tgts();
    set_tgt(5, 300, 230);
    pick(310, 240, busy_n);
    set_tgt(3, 100, 100);
    bus.click_m = 1'b1;
    step(1);
    bus.click_m = 1'b0;
    check("t6_m_busy", 32'(bus.busy), 0);
    step(20);
    check("t6_m_idx",    32'(bus.locked_idx), 5);
    check("t6_m_locked", 32'(bus.is_locked), 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
